// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, counter width and stream-lock state encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Wide enough for totals up to 4095 pixels/lines.
  localparam int CNT_W = 12;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    LOCKED   = 1'b1
  } vid_state_e;

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters advancing on the pixel enable, plus active/sync decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             ce_i,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active,
  output logic             hsync_n,
  output logic             vsync_n
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (ce_i) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt    = hcnt_q;
  assign vcnt    = vcnt_q;
  assign active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hsync_n = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
  assign vsync_n = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));

endmodule

// File: rtl/vga_video_out.sv
// VGA output stage: locks an upstream pixel stream to the raster on SOF and
// drives registered syncs/colour/DE, flagging stream misalignment in err_o.
module vga_video_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        pix_valid_i,
  input  logic        pix_sof_i,
  input  logic [11:0] pix_rgb_i,
  output logic        pix_ready_o,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        de_o,
  output logic        frame_start_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             active, hsync_n, vsync_n, at_origin;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .reset_i (reset_i),
    .ce_i    (ce_i),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .active  (active),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n)
  );

  assign at_origin = (hcnt == '0) && (vcnt == '0);

  vid_state_e  state_q, state_d;
  logic        ready, show, set_err;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, err_q, err_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    show    = 1'b0;
    set_err = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        // Non-SOF pixels are flushed at full clk rate; SOF waits for the origin.
        if (pix_valid_i && !pix_sof_i) begin
          ready = 1'b1;
        end else if (pix_valid_i && ce_i && at_origin) begin
          ready   = 1'b1;
          show    = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (ce_i && active) begin
          if (!pix_valid_i) begin
            set_err = 1'b1;
            state_d = WAIT_SOF;
          end else if (pix_sof_i && !at_origin) begin
            set_err = 1'b1;
            state_d = WAIT_SOF;
          end else begin
            ready = 1'b1;
            show  = 1'b1;
            if (!pix_sof_i && at_origin) begin
              set_err = 1'b1;
              state_d = WAIT_SOF;
            end
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  assign pix_ready_o = ready && reset_i;

  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    rgb_d = rgb_q;
    fs_d  = ce_i && at_origin;
    err_d = set_err ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    if (ce_i) begin
      hs_d  = hsync_n;
      vs_d  = vsync_n;
      de_d  = active;
      rgb_d = show ? pix_rgb_i : 12'h000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state_q <= WAIT_SOF;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
    end
  end

  assign vga_hsync     = hs_q;
  assign vga_vsync     = vs_q;
  assign vga_r         = rgb_q[11:8];
  assign vga_g         = rgb_q[7:4];
  assign vga_b         = rgb_q[3:0];
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_vga_video_out.sv
// Randomized bench for vga_video_out on a reduced raster, checked against a
// raster-position reference model and measured sync/frame timings.
module tb_vga_video_out;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic reset_i, ce_i, pix_valid_i, pix_sof_i, err_clr_i;
  logic [11:0] pix_rgb_i;
  logic pix_ready_o, vga_hsync, vga_vsync, de_o, frame_start_o, err_o;
  logic [3:0] vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  vga_video_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset_i(reset_i), .ce_i(ce_i),
    .pix_valid_i(pix_valid_i), .pix_sof_i(pix_sof_i), .pix_rgb_i(pix_rgb_i),
    .pix_ready_o(pix_ready_o), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .de_o(de_o),
    .frame_start_o(frame_start_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  int n_chk = 0, n_pass = 0;
  // reference raster position, lock flag and expected registered outputs
  int mh = 0, mv = 0;
  bit mlock = 0, merr = 0;
  bit e_hs = 1, e_vs = 1, e_de = 0, e_fs = 0;
  int e_rgb = 0;
  // upstream source and stimulus knobs
  int src_idx = 0, salt = 0;
  bit src_on = 0, hole = 0, early_sof = 0, ce_ph = 0;
  int ce_mode = 0, gap_pct = 0;
  // timing monitor
  int cyc = 0, hs_fall, hs_low, hs_per, vs_fall, vs_low, fs_cyc, frame_len;
  int de_acc = 0, de_frame = -1;
  bit hs_p = 1, vs_p = 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv, $time);
  endtask

  function automatic int pat(input int idx);
    return ((idx % HA) + (idx / HA) * 37 + salt) & 12'hfff;
  endfunction

  task automatic meas_clr();
    hs_fall = -1; hs_low = -1; hs_per = -1;
    vs_fall = -1; vs_low = -1; fs_cyc = -1; frame_len = -1;
  endtask

  task automatic step(input bit rst_n, input bit clr);
    bit ce, v, sof, rdy, show, set, nlock, act, at0;
    int rgb;
    @(negedge clk);
    case (ce_mode)
      0: ce = 1'b1;
      1: begin ce = ce_ph; ce_ph = !ce_ph; end
      default: ce = ($urandom_range(0, 3) != 0);
    endcase
    if (early_sof && mlock && mh == 5 && mv == 0 && ce) begin
      src_idx = 0;
      early_sof = 0;
    end
    v = src_on && ($urandom_range(0, 99) >= gap_pct) && !(hole && mlock && mh == 5 && mv == 3);
    sof = (src_idx == 0);
    rgb = pat(src_idx);
    reset_i = rst_n; ce_i = ce; err_clr_i = clr;
    pix_valid_i = v; pix_sof_i = sof; pix_rgb_i = 12'(rgb);
    #1;
    act = (mh < HA) && (mv < VA);
    at0 = (mh == 0) && (mv == 0);
    rdy = 0; show = 0; set = 0; nlock = mlock;
    if (!mlock) begin
      if (v && !sof) rdy = 1;
      else if (v && ce && at0) begin rdy = 1; show = 1; nlock = 1; end
    end else if (ce && act) begin
      if (!v || (sof && !at0)) begin set = 1; nlock = 0; end
      else begin
        rdy = 1; show = 1;
        if (!sof && at0) begin set = 1; nlock = 0; end
      end
    end
    if (!rst_n) rdy = 0;
    chk("ready", pix_ready_o, rdy);
    @(posedge clk);
    if (!rst_n) begin
      mh = 0; mv = 0; mlock = 0; merr = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_rgb = 0; e_fs = 0;
    end else begin
      e_fs = ce && at0;
      merr = set ? 1'b1 : (clr ? 1'b0 : merr);
      if (ce) begin
        e_hs = !(mh >= HA + HFP && mh < HA + HFP + HSW);
        e_vs = !(mv >= VA + VFP && mv < VA + VFP + VSW);
        e_de = act;
        e_rgb = show ? rgb : 0;
        mh++;
        if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
      end
      mlock = nlock;
      if (rdy && v) begin
        src_idx = (src_idx + 1) % (HA * VA);
        if (src_idx == 0) salt = $urandom_range(0, 4095);
      end
    end
    #1;
    cyc++;
    chk("hsync", vga_hsync, e_hs);
    chk("vsync", vga_vsync, e_vs);
    chk("de", de_o, e_de);
    chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    chk("frame_start", frame_start_o, e_fs);
    chk("err", err_o, merr);
    if (hs_p && !vga_hsync) begin
      if (hs_fall >= 0) hs_per = cyc - hs_fall;
      hs_fall = cyc;
    end
    if (!hs_p && vga_hsync && hs_fall >= 0) hs_low = cyc - hs_fall;
    if (vs_p && !vga_vsync) vs_fall = cyc;
    if (!vs_p && vga_vsync && vs_fall >= 0) vs_low = cyc - vs_fall;
    if (frame_start_o) begin
      if (fs_cyc >= 0) frame_len = cyc - fs_cyc;
      fs_cyc = cyc;
      de_frame = de_acc;
      de_acc = 0;
    end
    de_acc += int'(de_o);
    hs_p = vga_hsync; vs_p = vga_vsync;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic chk_timing(input int k);
    chk("hs_low", hs_low, HSW * k);
    chk("hs_period", hs_per, HT * k);
    chk("vs_low", vs_low, VSW * HT * k);
    chk("frame_len", frame_len, FR * k);
  endtask

  initial begin
    reset_i = 0; ce_i = 0; pix_valid_i = 0; pix_sof_i = 0; pix_rgb_i = '0; err_clr_i = 0;
    meas_clr();
    salt = $urandom_range(0, 4095);

    // reset and free-running timing, no stream
    repeat (3) step(1'b0, 1'b0);
    chk("rst_hsync", vga_hsync, 1);
    chk("rst_de", de_o, 0);
    run(2 * FR + 10);
    chk_timing(1);

    // aligned stream, full frames, no errors
    src_on = 1; src_idx = 0;
    run(3 * FR);
    chk("stream_de_count", de_frame, HA * VA);
    chk("stream_err", err_o, 0);

    // underflow inside the active area, relock on next SOF, then clear
    hole = 1;
    run(FR);
    hole = 0;
    run(2 * FR);
    chk("underflow_err", err_o, 1);
    step(1'b1, 1'b1);
    chk("err_cleared", err_o, 0);
    run(FR);

    // SOF presented early while locked
    early_sof = 1;
    run(2 * FR);
    chk("early_sof_err", err_o, 1);
    step(1'b1, 1'b1);
    run(FR);

    // ce every other clock doubles all timings
    ce_mode = 1; meas_clr();
    run(4 * FR + 20);
    chk_timing(2);

    // random enables, stream gaps and clears
    ce_mode = 2; gap_pct = 3;
    for (int i = 0; i < 5 * FR; i++) step(1'b1, $urandom_range(0, 49) == 0);

    // one-clock reset mid-frame
    ce_mode = 0; gap_pct = 0;
    for (int i = 0; i < 2 * FR && !(mh == 10 && mv == 5); i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("midrst_err", err_o, 0);
    chk("midrst_rgb", {vga_r, vga_g, vga_b}, 0);
    step(1'b1, 1'b0);
    chk("fs_after_rst", frame_start_o, 1);
    meas_clr();
    run(2 * FR + 10);
    chk("frame_len_after_rst", frame_len, FR);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_video_out.md
VGA_VIDEO_OUT -- requirements
Module: vga_video_out

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal porch and sync widths in pixels.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 The block SHALL have parameter V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical porch and sync widths in lines.
REQ-005 The block SHALL have port clk, input, 1: single clock for all logic.
REQ-006 The block SHALL have port reset_i, input, 1: reset, synchronous, active-low.
REQ-007 The block SHALL have port ce_i, input, 1: pixel-rate enable; timing advances only when high.
REQ-008 The block SHALL have port pix_valid_i, input, 1: upstream pixel valid.
REQ-009 The block SHALL have port pix_sof_i, input, 1: marks the first pixel of a frame, qualified by pix_valid_i.
REQ-010 The block SHALL have port pix_rgb_i, input, 12: {R[11:8],G[7:4],B[3:0]}.
REQ-011 The block SHALL have port pix_ready_o, output, 1: pixel consumed this cycle when high with pix_valid_i.
REQ-012 The block SHALL have ports vga_hsync and vga_vsync, output, 1 each: syncs, negative polarity.
REQ-013 The block SHALL have ports vga_r, vga_g and vga_b, output, 4 each: colour.
REQ-014 The block SHALL have port de_o, output, 1: registered active-video flag aligned with colour.
REQ-015 The block SHALL have port frame_start_o, output, 1: one-cycle pulse at pixel (0,0).
REQ-016 The block SHALL have port err_o, output, 1: sticky stream error.
REQ-017 The block SHALL have port err_clr_i, input, 1: clears err_o.

Function
REQ-018 hcnt SHALL count 0..H_TOTAL-1 (800) and vcnt SHALL count 0..V_TOTAL-1 (525), advancing on ce_i only; hcnt wraps to 0 and increments vcnt; both wrap to 0 after (799,524).
REQ-019 Active SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE; hsync SHALL be low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751]); vsync SHALL be low for vcnt in [490,491].
REQ-020 All VGA outputs and de_o SHALL be registered, one clk after the counter state they reflect, and SHALL update only on ce_i cycles.
REQ-021 Colour SHALL be 0 whenever not active or no pixel is consumed.
REQ-022 The state machine SHALL have WAIT_SOF and LOCKED states, with reset to WAIT_SOF.
REQ-023 In WAIT_SOF, pix_ready_o SHALL be 1 when pix_valid_i and !pix_sof_i; these pixels are discarded.
REQ-024 In WAIT_SOF, a valid SOF pixel SHALL be held (ready 0) until ce_i with hcnt=0 and vcnt=0; it is then consumed, displayed, and the state becomes LOCKED.
REQ-025 In LOCKED, pix_ready_o SHALL be ce_i and active, combinationally.
REQ-026 In LOCKED, an active ce_i cycle with !pix_valid_i (underflow) SHALL output black, set err_o, and go to WAIT_SOF.
REQ-027 In LOCKED, a valid SOF pixel that is not at (0,0) SHALL NOT be consumed, SHALL set err_o, and SHALL go to WAIT_SOF.
REQ-028 A non-SOF pixel at (0,0) in LOCKED SHALL be consumed and SHALL set err_o, and the state SHALL go to WAIT_SOF.
REQ-029 frame_start_o SHALL pulse for one clk, aligned with the pixel (0,0) output, every frame regardless of state.
REQ-030 When err_clr_i coincides with a new error, the set SHALL win.

Reset
REQ-031 On reset_i=0 at a clk edge, the block SHALL set: hcnt=vcnt=0, state WAIT_SOF, vga_hsync=vga_vsync=1, rgb=0, de_o=0, frame_start_o=0, err_o=0, pix_ready_o=0; reset mid-frame SHALL restart timing at (0,0).

Structure
REQ-032 Timing defaults and the state enum SHALL live in package vga_pkg.
REQ-033 Counters and sync decode SHALL be a sub-module vga_timing (outputs hcnt, vcnt, active, hsync_n, vsync_n).

Verification
REQ-034 After reset with ce_i=1 for 2 frames, the bench SHALL see an hsync low width of 96 clks, a period of 800, a vsync low of 2 lines, and a frame of 420000 clks.
REQ-035 With a stream of 307200 pixels per frame where the first has SOF, pattern rgb=hcnt[11:0], the bench SHALL see de_o high for 640x480, colour matching the pattern with 1-clk latency, and err_o=0.
REQ-036 Withholding pix_valid_i at (100,10) SHALL produce black from there, err_o=1, lock on the next SOF at (0,0), and err_clr_i then clearing err_o.
REQ-037 Presenting SOF at (5,0) while LOCKED SHALL keep it unconsumed, set err_o, and display it at the next (0,0).
REQ-038 With ce_i toggling every other clk, the bench SHALL see all timings doubled and outputs changing only after ce_i cycles.
REQ-039 Asserting reset_i=0 at (300,200) for 1 clk SHALL make outputs match the reset values, then (0,0) timing restarts.
